// File: rtl/gba_cmd_parser.sv
// Framed command front end: assembles 10-byte host frames, validates them, answers ACK/NAK
// and kicks GBAPakReader with an offset/length pair, then holds off until the dump completes.
module gba_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 2700000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        pin_clk,
  input  logic        rst,
  input  logic        uart_byteReady,
  input  logic [7:0]  uart_DataIn,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  input  logic        resp_ready,
  output logic [23:0] pak_readOffset,
  output logic [24:0] pak_readLength,
  output logic        pak_startDump,
  input  logic        pak_dumpCompleted,
  output logic        busy,
  output logic [2:0]  last_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE, RX_OP, RX_OFF, RX_LEN, RX_CHK, CHECK, RESP, START, BUSY
  } state_t;

  state_t        state;
  logic [TW-1:0] toCnt;
  logic [1:0]    byteIdx;
  logic [7:0]    op, chkSum, rxChk;
  logic [23:0]   off;
  logic [31:0]   len;
  logic [2:0]    errCode;
  logic [25:0]   endAddr;
  logic          timedOut;

  assign timedOut = (toCnt == TW'(TIMEOUT_CYCLES - 1));

  // Validation rules, evaluated in priority order; 0 means the frame is good.
  always_comb begin
    endAddr = {2'b00, off} + len[25:0];
    errCode = 3'd0;
    if (chkSum != rxChk)
      errCode = 3'd1;
    else if (op != 8'h01 && op != 8'h02)
      errCode = 3'd2;
    else if (len == 32'd0 || len > 32'h0100_0000)
      errCode = 3'd3;
    else if (op == 8'h01 && endAddr > 26'h100_0000)
      errCode = 3'd4;
  end

  always_ff @(posedge pin_clk) begin
    if (rst) begin
      state          <= IDLE;
      toCnt          <= '0;
      byteIdx        <= '0;
      op             <= '0;
      chkSum         <= '0;
      rxChk          <= '0;
      off            <= '0;
      len            <= '0;
      resp_valid     <= 1'b0;
      resp_data      <= '0;
      pak_readOffset <= '0;
      pak_readLength <= '0;
      pak_startDump  <= 1'b0;
      busy           <= 1'b0;
      last_err       <= '0;
    end else begin
      pak_startDump <= 1'b0;
      case (state)
        IDLE: if (uart_byteReady && uart_DataIn == SYNC_BYTE) begin
          state  <= RX_OP;
          chkSum <= '0;
          toCnt  <= '0;
        end
        RX_OP, RX_OFF, RX_LEN, RX_CHK: begin
          if (uart_byteReady) begin
            toCnt <= '0;
            case (state)
              RX_OP: begin
                op      <= uart_DataIn;
                chkSum  <= chkSum ^ uart_DataIn;
                byteIdx <= '0;
                state   <= RX_OFF;
              end
              RX_OFF: begin
                off     <= {off[15:0], uart_DataIn};
                chkSum  <= chkSum ^ uart_DataIn;
                byteIdx <= (byteIdx == 2'd2) ? 2'd0 : byteIdx + 2'd1;
                if (byteIdx == 2'd2) state <= RX_LEN;
              end
              RX_LEN: begin
                len     <= {len[23:0], uart_DataIn};
                chkSum  <= chkSum ^ uart_DataIn;
                byteIdx <= byteIdx + 2'd1;
                if (byteIdx == 2'd3) state <= RX_CHK;
              end
              default: begin
                rxChk <= uart_DataIn;
                state <= CHECK;
              end
            endcase
          end else if (timedOut) begin
            // A stalled host gets a NAK straight away, bypassing CHECK.
            resp_valid <= 1'b1;
            resp_data  <= NAK;
            last_err   <= 3'd5;
            state      <= RESP;
          end else begin
            toCnt <= toCnt + TW'(1);
          end
        end
        CHECK: begin
          resp_valid <= 1'b1;
          state      <= RESP;
          if (errCode == 3'd0) begin
            resp_data <= ACK;
          end else begin
            resp_data <= NAK;
            last_err  <= errCode;
          end
        end
        RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          if (resp_data == ACK && op == 8'h01) begin
            pak_readOffset <= off;
            pak_readLength <= len[24:0];
            pak_startDump  <= 1'b1;
            busy           <= 1'b1;
            state          <= START;
          end else begin
            state <= IDLE;
          end
        end
        START: state <= BUSY;
        BUSY: if (pak_dumpCompleted) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_cmd_parser.sv
// Directed bench for gba_cmd_parser: frame validation, latency, timeout, backpressure, busy and reset.
module tb_gba_cmd_parser;

  localparam int TO = 40;

  logic        pin_clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_byteReady = 1'b0;
  logic [7:0]  uart_DataIn = '0;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_ready = 1'b0;
  logic [23:0] pak_readOffset;
  logic [24:0] pak_readLength;
  logic        pak_startDump;
  logic        pak_dumpCompleted = 1'b0;
  logic        busy;
  logic [2:0]  last_err;

  int nTests = 0;
  int nFail = 0;
  int startCnt = 0;
  logic [2:0] expErr = '0;

  gba_cmd_parser #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .pin_clk(pin_clk), .rst(rst),
    .uart_byteReady(uart_byteReady), .uart_DataIn(uart_DataIn),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .pak_readOffset(pak_readOffset), .pak_readLength(pak_readLength),
    .pak_startDump(pak_startDump), .pak_dumpCompleted(pak_dumpCompleted),
    .busy(busy), .last_err(last_err)
  );

  always #5 pin_clk = ~pin_clk;
  always @(posedge pin_clk) if (pak_startDump) startCnt <= startCnt + 1;

  function automatic logic [7:0] calc_chk(input logic [7:0] op, input logic [23:0] off,
                                          input logic [31:0] len);
    return op ^ off[23:16] ^ off[15:8] ^ off[7:0] ^ len[31:24] ^ len[23:16] ^ len[15:8] ^ len[7:0];
  endfunction

  task automatic tick();
    @(posedge pin_clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_byteReady = 1'b1;
    uart_DataIn    = b;
    tick();
    uart_byteReady = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] op, input logic [23:0] off, input logic [31:0] len,
                            input logic [7:0] flip, input int first, input int last);
    logic [7:0] fr [10];
    fr[0] = 8'hA5; fr[1] = op;
    fr[2] = off[23:16]; fr[3] = off[15:8]; fr[4] = off[7:0];
    fr[5] = len[31:24]; fr[6] = len[23:16]; fr[7] = len[15:8]; fr[8] = len[7:0];
    fr[9] = calc_chk(op, off, len) ^ flip;
    for (int i = first; i <= last; i++) send_byte(fr[i]);
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid) got = 1'b1;
      else tick();
    end
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic exchange(input logic [7:0] op, input logic [23:0] off, input logic [31:0] len,
                          input logic [7:0] flip, output bit got, output logic [7:0] data);
    send_bytes(op, off, len, flip, 0, 9);
    wait_valid(got);
    data = resp_data;
    if (got) accept();
  endtask

  task automatic finish_dump();
    tick();
    pak_dumpCompleted = 1'b1;
    tick();
    pak_dumpCompleted = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    tick();
    nTests++;
    if ({resp_valid, resp_data, pak_readOffset, pak_readLength, pak_startDump, busy, last_err} !== '0) begin
      nFail++;
      $display("FAIL reset_state: got rv=%b rd=%h off=%h len=%h sd=%b busy=%b err=%0d, want all 0",
               resp_valid, resp_data, pak_readOffset, pak_readLength, pak_startDump, busy, last_err);
    end
  endtask

  task automatic test_dump_ack();
    int s0 = startCnt;
    send_bytes(8'h01, 24'h0, 32'h0020_0000, 8'h00, 0, 9);
    nTests++;
    if (resp_valid !== 1'b0) begin nFail++; $display("FAIL ack_latency_early: rv=%b want 0", resp_valid); end
    tick();
    nTests++;
    if (resp_valid !== 1'b1 || resp_data !== 8'h06) begin
      nFail++; $display("FAIL ack_latency: rv=%b rd=%h want 1/06", resp_valid, resp_data);
    end
    accept();
    nTests++;
    if (pak_startDump !== 1'b1 || busy !== 1'b1 || resp_valid !== 1'b0) begin
      nFail++; $display("FAIL start_pulse: sd=%b busy=%b rv=%b want 1/1/0", pak_startDump, busy, resp_valid);
    end
    nTests++;
    if (pak_readOffset !== 24'd0 || pak_readLength !== 25'd2097152) begin
      nFail++; $display("FAIL start_args: off=%0d len=%0d want 0/2097152", pak_readOffset, pak_readLength);
    end
    tick();
    nTests++;
    if (pak_startDump !== 1'b0 || busy !== 1'b1 || startCnt - s0 != 1) begin
      nFail++; $display("FAIL start_one_cycle: sd=%b busy=%b pulses=%0d want 0/1/1", pak_startDump, busy, startCnt - s0);
    end
  endtask

  task automatic test_busy_ignore();
    int s0 = startCnt;
    bit got;
    logic [7:0] d;
    send_bytes(8'h02, 24'h0, 32'h1, 8'h00, 0, 9);
    repeat (5) tick();
    nTests++;
    if (resp_valid !== 1'b0 || busy !== 1'b1 || pak_readLength !== 25'd2097152 || startCnt != s0) begin
      nFail++; $display("FAIL busy_ignore: rv=%b busy=%b len=%0d pulses=%0d want 0/1/2097152/0",
                        resp_valid, busy, pak_readLength, startCnt - s0);
    end
    pak_dumpCompleted = 1'b1;
    tick();
    pak_dumpCompleted = 1'b0;
    nTests++;
    if (busy !== 1'b0) begin nFail++; $display("FAIL busy_clear: busy=%b want 0", busy); end
    exchange(8'h02, 24'h0, 32'h1, 8'h00, got, d);
    nTests++;
    if (!got || d !== 8'h06) begin nFail++; $display("FAIL after_busy_ping: got=%b rd=%h want 1/06", got, d); end
  endtask

  task automatic test_bad_chk();
    int s0 = startCnt;
    bit got;
    logic [7:0] d;
    exchange(8'h01, 24'h0, 32'h0020_0000, 8'h03, got, d);
    expErr = 3'd1;
    repeat (3) tick();
    nTests++;
    if (!got || d !== 8'h15 || last_err !== 3'd1 || busy !== 1'b0 || startCnt != s0) begin
      nFail++; $display("FAIL bad_chk: got=%b rd=%h err=%0d busy=%b pulses=%0d want 1/15/1/0/0",
                        got, d, last_err, busy, startCnt - s0);
    end
    exchange(8'h02, 24'h0, 32'h1, 8'h00, got, d);
    repeat (3) tick();
    nTests++;
    if (!got || d !== 8'h06 || busy !== 1'b0 || last_err !== 3'd1 || startCnt != s0) begin
      nFail++; $display("FAIL ping_after_nak: got=%b rd=%h busy=%b err=%0d want 1/06/0/1", got, d, busy, last_err);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [23:0] off;
    logic [31:0] len;
    logic [7:0]  flip;
    logic [7:0]  resp;
    logic [2:0]  err;
  } vec_t;

  task automatic test_rules();
    vec_t v [12];
    bit got;
    logic [7:0] d;
    v[0]  = '{8'h01, 24'h1FFFFF, 32'd97,        8'h00, 8'h06, 3'd0};
    v[1]  = '{8'h01, 24'hFFFFFF, 32'd2,         8'h00, 8'h15, 3'd4};
    v[2]  = '{8'h03, 24'h0,      32'd1,         8'h00, 8'h15, 3'd2};
    v[3]  = '{8'h02, 24'h0,      32'd0,         8'h00, 8'h15, 3'd3};
    v[4]  = '{8'h02, 24'h0,      32'h0100_0001, 8'h00, 8'h15, 3'd3};
    v[5]  = '{8'h02, 24'h0,      32'h0200_0000, 8'h00, 8'h15, 3'd3};
    v[6]  = '{8'h02, 24'h0,      32'h8000_0001, 8'h00, 8'h15, 3'd3};
    v[7]  = '{8'h01, 24'h0,      32'h0100_0000, 8'h00, 8'h06, 3'd0};
    v[8]  = '{8'h01, 24'h1,      32'h0100_0000, 8'h00, 8'h15, 3'd4};
    v[9]  = '{8'h03, 24'h0,      32'd0,         8'h01, 8'h15, 3'd1};
    v[10] = '{8'h04, 24'h0,      32'd0,         8'h00, 8'h15, 3'd2};
    v[11] = '{8'h02, 24'hFFFFFF, 32'h0100_0000, 8'h00, 8'h06, 3'd0};
    for (int i = 0; i < 12; i++) begin
      int s0 = startCnt;
      exchange(v[i].op, v[i].off, v[i].len, v[i].flip, got, d);
      if (v[i].err != 3'd0) expErr = v[i].err;
      nTests++;
      if (!got || d !== v[i].resp || last_err !== expErr) begin
        nFail++; $display("FAIL rule_vec%0d: got=%b rd=%h err=%0d want rd=%h err=%0d", i, got, d, last_err, v[i].resp, expErr);
      end
      if (v[i].resp == 8'h06 && v[i].op == 8'h01) begin
        nTests++;
        if (pak_startDump !== 1'b1 || pak_readOffset !== v[i].off || pak_readLength !== v[i].len[24:0]) begin
          nFail++; $display("FAIL rule_dump%0d: sd=%b off=%h len=%h want 1/%h/%h", i, pak_startDump,
                            pak_readOffset, pak_readLength, v[i].off, v[i].len[24:0]);
        end
        finish_dump();
      end else begin
        repeat (2) tick();
        nTests++;
        if (startCnt != s0 || busy !== 1'b0) begin
          nFail++; $display("FAIL rule_nodump%0d: pulses=%0d busy=%b want 0/0", i, startCnt - s0, busy);
        end
      end
    end
  endtask

  task automatic test_timeout();
    bit got;
    send_bytes(8'h01, 24'h0, 32'h1, 8'h00, 0, 3);
    repeat (TO - 1) tick();
    nTests++;
    if (resp_valid !== 1'b0) begin nFail++; $display("FAIL timeout_early: rv=%b want 0", resp_valid); end
    tick();
    expErr = 3'd5;
    nTests++;
    if (resp_valid !== 1'b1 || resp_data !== 8'h15 || last_err !== 3'd5) begin
      nFail++; $display("FAIL timeout_nak: rv=%b rd=%h err=%0d want 1/15/5", resp_valid, resp_data, last_err);
    end
    accept();
    // Byte lands on the very cycle the counter would expire.
    send_bytes(8'h02, 24'h0, 32'h1, 8'h00, 0, 3);
    repeat (TO - 1) tick();
    send_bytes(8'h02, 24'h0, 32'h1, 8'h00, 4, 9);
    wait_valid(got);
    nTests++;
    if (!got || resp_data !== 8'h06 || last_err !== 3'd5) begin
      nFail++; $display("FAIL timeout_byte_wins: got=%b rd=%h err=%0d want 1/06/5", got, resp_data, last_err);
    end
    if (got) accept();
  endtask

  task automatic test_backpressure();
    bit got;
    int s0;
    int bad = 0;
    send_bytes(8'h01, 24'h123456, 32'h10, 8'h00, 0, 9);
    wait_valid(got);
    s0 = startCnt;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== 8'h06 || pak_startDump !== 1'b0) bad++;
      tick();
    end
    nTests++;
    if (!got || bad != 0 || startCnt != s0) begin
      nFail++; $display("FAIL backpressure_hold: got=%b unstable=%0d pulses=%0d want 1/0/0", got, bad, startCnt - s0);
    end
    accept();
    nTests++;
    if (pak_startDump !== 1'b1 || pak_readOffset !== 24'h123456 || pak_readLength !== 25'h10) begin
      nFail++; $display("FAIL backpressure_start: sd=%b off=%h len=%h want 1/123456/10",
                        pak_startDump, pak_readOffset, pak_readLength);
    end
    finish_dump();
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [7:0] d;
    send_bytes(8'h01, 24'h0, 32'h0000_0100, 8'h00, 0, 6);
    pulse_reset();
    nTests++;
    if ({resp_valid, resp_data, pak_readOffset, pak_readLength, pak_startDump, busy, last_err} !== '0) begin
      nFail++; $display("FAIL reset_rx_len: rv=%b rd=%h off=%h len=%h err=%0d want all 0",
                        resp_valid, resp_data, pak_readOffset, pak_readLength, last_err);
    end
    exchange(8'h01, 24'h000100, 32'h0000_0200, 8'h00, got, d);
    tick();
    nTests++;
    if (!got || d !== 8'h06 || busy !== 1'b1) begin
      nFail++; $display("FAIL pre_reset_dump: got=%b rd=%h busy=%b want 1/06/1", got, d, busy);
    end
    pulse_reset();
    nTests++;
    if ({resp_valid, resp_data, pak_readOffset, pak_readLength, pak_startDump, busy, last_err} !== '0) begin
      nFail++; $display("FAIL reset_busy: rv=%b rd=%h off=%h len=%h busy=%b want all 0",
                        resp_valid, resp_data, pak_readOffset, pak_readLength, busy);
    end
    exchange(8'h02, 24'h0, 32'h1, 8'h00, got, d);
    nTests++;
    if (!got || d !== 8'h06) begin nFail++; $display("FAIL post_reset_ping: got=%b rd=%h want 1/06", got, d); end
  endtask

  initial begin
    test_reset();
    test_dump_ack();
    test_busy_ignore();
    test_bad_chk();
    test_rules();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
